// File: rtl/alu_reg_mem_sequencer.sv
// Sequencer for the ALU / register file / data memory datapath.
// Optional feature macro: SEQ_MEM_WAIT_EN (memory store waits for mem_ack).
module alu_reg_mem_sequencer #(
    parameter int REG_AW = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [MEM_AW-1:0] cmd_maddr,
    output logic [REG_AW-1:0] rf_ra_addr,
    output logic [REG_AW-1:0] rf_rb_addr,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [2:0]        alu_op,
    output logic              alu_latch,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              done,
    output logic [7:0]        op_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] ra_q;
    logic [REG_AW-1:0] rb_q;
    logic [REG_AW-1:0] rd_q;
    logic [MEM_AW-1:0] maddr_q;
    logic [7:0]        count_q;
    logic              accept;

    assign accept = (state == S_IDLE) && cmd_valid;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (cmd_valid) state_n = S_READ;
            S_READ: state_n = S_EXEC;
            S_EXEC: state_n = S_WB;
            S_WB:   state_n = op_q[3] ? S_MEM : S_DONE;
`ifdef SEQ_MEM_WAIT_EN
            S_MEM:  if (mem_ack) state_n = S_DONE;
`else
            S_MEM:  state_n = S_DONE;
`endif
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

`ifndef SEQ_MEM_WAIT_EN
    logic unused_mem_ack;
    assign unused_mem_ack = mem_ack;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rd_q    <= '0;
            maddr_q <= '0;
            count_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q    <= cmd_op;
                ra_q    <= cmd_ra;
                rb_q    <= cmd_rb;
                rd_q    <= cmd_rd;
                maddr_q <= cmd_maddr;
            end
            if (state == S_DONE) count_q <= count_q + 8'd1;
        end
    end

    // Strobes decode the state register, so an async reset kills them at once.
    assign cmd_ready  = (state == S_IDLE);
    assign alu_latch  = (state == S_EXEC);
    assign rf_we      = (state == S_WB) && (rd_q != '0);
    assign mem_we     = (state == S_MEM);
    assign done       = (state == S_DONE);
    assign rf_ra_addr = ra_q;
    assign rf_rb_addr = rb_q;
    assign rf_wa      = rd_q;
    assign alu_op     = op_q[2:0];
    assign mem_addr   = maddr_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_reg_mem_sequencer.sv
// Directed bench for alu_reg_mem_sequencer: vector table plus
// hand-written busy, mid-reset and counter-wrap sequences.
module tb_alu_reg_mem_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_ra;
    logic [3:0] cmd_rb;
    logic [3:0] cmd_rd;
    logic [7:0] cmd_maddr;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic       rf_we;
    logic [3:0] rf_wa;
    logic [2:0] alu_op;
    logic       alu_latch;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic       done;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_count = 8'd0;

    always #5 clk = ~clk;

    alu_reg_mem_sequencer #(.REG_AW(4), .MEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .cmd_rd(cmd_rd), .cmd_maddr(cmd_maddr),
        .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
        .rf_we(rf_we), .rf_wa(rf_wa), .alu_op(alu_op),
        .alu_latch(alu_latch), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .done(done), .op_count(op_count)
    );

    typedef struct {
        logic [3:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [3:0] rd;
        logic [7:0] maddr;
        logic       exp_rf_we;
        logic       exp_store;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input vec_t v);
        @(negedge clk);
        cmd_op = v.op; cmd_ra = v.ra; cmd_rb = v.rb;
        cmd_rd = v.rd; cmd_maddr = v.maddr; cmd_valid = 1'b1;
        check("ready_idle", cmd_ready, 1);
        cyc();
        cmd_valid = 1'b0;
        check("read_ready", cmd_ready, 0);
        check("read_ra", rf_ra_addr, v.ra);
        check("read_rb", rf_rb_addr, v.rb);
        check("read_latch", alu_latch, 0);
        cyc();
        check("exec_latch", alu_latch, 1);
        check("exec_aluop", alu_op, v.op[2:0]);
        check("exec_we", rf_we, 0);
        cyc();
        check("wb_we", rf_we, v.exp_rf_we);
        check("wb_wa", rf_wa, v.rd);
        check("wb_latch", alu_latch, 0);
        check("wb_mem", mem_we, 0);
        cyc();
        if (v.exp_store) begin
`ifdef SEQ_MEM_WAIT_EN
            for (int k = 0; k < 4; k++) begin
                check("mem_we_hold", mem_we, 1);
                check("mem_done_lo", done, 0);
                if (k == 3) begin
                    @(negedge clk);
                    mem_ack = 1'b1;
                end
                cyc();
                mem_ack = 1'b0;
            end
`else
            check("mem_we", mem_we, 1);
            check("mem_addr", mem_addr, v.maddr);
            check("mem_done_lo", done, 0);
            cyc();
`endif
        end
        check("done", done, 1);
        check("done_mem", mem_we, 0);
        exp_count = exp_count + 8'd1;
        cyc();
        check("post_done", done, 0);
        check("post_ready", cmd_ready, 1);
        check("count", op_count, exp_count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_count"}, op_count, 0);
        check({tag, "_strobes"}, {rf_we, alu_latch, mem_we, done}, 0);
        check({tag, "_addrs"}, {rf_ra_addr, rf_rb_addr, rf_wa, alu_op, mem_addr}, 0);
    endtask

    initial begin
        int guard;
        int first_done;
        int dones;
        vecs[0] = '{4'b0010, 4'd1,  4'd2,  4'd3,  8'h00, 1'b1, 1'b0};
        vecs[1] = '{4'b1001, 4'd4,  4'd5,  4'd6,  8'hA5, 1'b1, 1'b1};
        vecs[2] = '{4'b0111, 4'd15, 4'd14, 4'd0,  8'h00, 1'b0, 1'b0};
        vecs[3] = '{4'b1000, 4'd7,  4'd8,  4'd0,  8'h3C, 1'b0, 1'b1};
        vecs[4] = '{4'b0101, 4'd0,  4'd9,  4'd15, 8'hFF, 1'b1, 1'b0};
        vecs[5] = '{4'b1110, 4'd10, 4'd11, 4'd12, 8'h00, 1'b1, 1'b1};

        reset = 1'b0; cmd_valid = 1'b0; mem_ack = 1'b0;
        cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_maddr = '0;
        repeat (50) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        reset = 1'b1;
        cyc();
        check_reset_outputs("after_reset");

        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);

        // Busy handling: command A (rd=0) then B held valid while busy.
        @(negedge clk);
        cmd_op = 4'b0011; cmd_ra = 4'd2; cmd_rb = 4'd3;
        cmd_rd = 4'd0; cmd_maddr = 8'h11; cmd_valid = 1'b1;
        cyc();
        cmd_op = 4'b0100; cmd_ra = 4'd9; cmd_rb = 4'd8; cmd_rd = 4'd7;
        for (int c = 1; c <= 5; c++) begin
            check("busy_ra_hold", rf_ra_addr, 4'd2);
            check("busy_rd0_we", rf_we, 0);
            check("busy_ready", cmd_ready, (c == 5) ? 1 : 0);
            check("busy_done", done, (c == 4) ? 1 : 0);
            cyc();
        end
        exp_count = exp_count + 8'd1;
        cmd_valid = 1'b0;
        check("b_accept_ready", cmd_ready, 0);
        check("b_accept_ra", rf_ra_addr, 4'd9);
        check("b_accept_rd", rf_wa, 4'd7);
        guard = 0;
        while (!done && guard < 20) begin
            cyc();
            guard++;
        end
        check("b_done_timeout", (guard < 20), 1);
        exp_count = exp_count + 8'd1;
        cyc();
        check("b_count", op_count, exp_count);

        // Mid-operation reset during EXEC.
        @(negedge clk);
        cmd_op = 4'b1010; cmd_ra = 4'd5; cmd_rb = 4'd6;
        cmd_rd = 4'd4; cmd_maddr = 8'h77; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        cyc();
        check("pre_abort_latch", alu_latch, 1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int c = 0; c < 4; c++) begin
            cyc();
            check("abort_no_done", {done, rf_we, mem_we}, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_count = 8'd0;
        run_cmd(vecs[1]);

        // Counter wrap with back-to-back commands.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_count = 8'd0;
        cmd_op = 4'b0001; cmd_rd = 4'd1; cmd_valid = 1'b1;
        dones = 0; guard = 0; first_done = 0;
        while (dones < 256 && guard < 2000) begin
            cyc();
            guard++;
            if (done) begin
                if (dones == 0) first_done = guard;
                dones++;
                if (dones == 255) check("count_255", op_count, 8'd254);
                if (dones == 256) cmd_valid = 1'b0;
            end
        end
        check("wrap_timeout", (dones == 256), 1);
        check("wrap_throughput", guard - first_done, 255 * 5);
        cyc();
        check("wrap_count", op_count, 8'd0);
        check("wrap_idle", cmd_ready, 1);
        cyc();
        check("wrap_no_extra", cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
